tt_um_serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor tile, the counterpart to the team's half-adder tile: where that tile forms a sum bit combinationally, this block subtracts two WIDTH-bit operands streamed LSB-first and carries the borrow across cycles. It uses the standard tile pinout. Each accepted bit pair yields a registered difference bit. After the last bit, the block presents the full difference word on the bidirectional pins, plus a borrow flag and a one-cycle done pulse.

---
 rtl/tt_um_serial_subtractor.sv | 106 ++++++++++
 tb/tb_tt_um_serial_subtractor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial unsigned subtractor tile: two LSB-first operand streams in, registered
// difference bit per accepted pair, full difference word plus borrow and done at word end.
module tt_um_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             bin_q;
    logic [WIDTH-1:0] sreg;
    logic             diff_p1;
    logic             borrow_p1;
    logic             done_p1;
    logic             busy_p1;
    logic             frame_err_p1;
    logic [7:0]       word_p1;

    // Returns {borrow_out, difference} of a single-bit full subtractor.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
        return {(~a & b) | (~(a ^ b) & bin), a ^ b ^ bin};
    endfunction

    // stage 0: decode the incoming bit pair and form the next datapath values
    logic             a_p0, b_p0, vld_p0, sof_p0;
    logic             bin_p0, d_p0, bout_p0, last_p0;
    logic [WIDTH-1:0] shifted_p0;
    logic [7:0]       word_ext_p0;

    assign a_p0       = ui_in[0];
    assign b_p0       = ui_in[1];
    assign vld_p0     = ui_in[2];
    assign sof_p0     = ui_in[3];
    assign bin_p0     = (state == SHIFT && !sof_p0) ? bin_q : 1'b0;
    assign {bout_p0, d_p0} = full_sub(a_p0, b_p0, bin_p0);
    assign shifted_p0 = {d_p0, sreg[WIDTH-1:1]};
    assign last_p0    = (state == SHIFT) && !sof_p0 && (cnt == CW'(WIDTH - 1));

    always_comb begin
        word_ext_p0 = '0;
        word_ext_p0[WIDTH-1:0] = shifted_p0;
    end

    // stage 1: registered state and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bin_q        <= 1'b0;
            sreg         <= '0;
            diff_p1      <= 1'b0;
            borrow_p1    <= 1'b0;
            done_p1      <= 1'b0;
            busy_p1      <= 1'b0;
            frame_err_p1 <= 1'b0;
            word_p1      <= '0;
        end else begin
            done_p1 <= 1'b0;
            if (vld_p0) begin
                if (sof_p0 || state == SHIFT) begin
                    diff_p1 <= d_p0;
                    bin_q   <= bout_p0;
                    sreg    <= shifted_p0;
                end
                if (sof_p0) begin
                    // an sof inside a word aborts it; from IDLE it clears the error
                    frame_err_p1 <= (state == SHIFT);
                    state        <= SHIFT;
                    busy_p1      <= 1'b1;
                    cnt          <= CW'(1);
                end else if (state == IDLE) begin
                    frame_err_p1 <= 1'b1;
                end else if (last_p0) begin
                    word_p1   <= word_ext_p0;
                    borrow_p1 <= bout_p0;
                    done_p1   <= 1'b1;
                    state     <= IDLE;
                    busy_p1   <= 1'b0;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign uo_out  = {3'b000, frame_err_p1, busy_p1, done_p1, borrow_p1, diff_p1};
    assign uio_out = word_p1;
    assign uio_oe  = 8'hFF;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, ui_in[7:4], uio_in, sreg[0]};

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Bench for the bit-serial subtractor: directed word stream, scoreboard of expected
// words and difference bits, and a small control model for busy/done/frame_err.
module tb_tt_um_serial_subtractor;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

    always #5 clk = ~clk;

    tt_um_serial_subtractor #(.WIDTH(W)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int n_words = 0, n_done_seen = 0;

    logic [1:0] diff_q[$];   // {check, expected diff_bit}
    logic [8:0] word_q[$];   // {borrow, word}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // control model and scoreboard consumer, sampled 1 time unit after each rising edge
    logic       m_busy = 1'b0, m_done = 1'b0, m_fe = 1'b0;
    int         m_cnt = 0;
    logic [7:0] exp_word = 8'h00;
    logic       exp_bor = 1'b0;

    always @(posedge clk) begin
        logic v, s;
        logic [1:0] de;
        logic [8:0] we;
        v = ui_in[2] && rst_n;
        s = ui_in[3];
        #1;
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_fe = 1'b0; m_cnt = 0;
            exp_word = 8'h00; exp_bor = 1'b0;
            chk("rst_uo_out", uo_out, 8'h00);
            chk("rst_uio_out", uio_out, 8'h00);
        end else begin
            m_done = 1'b0;
            if (v) begin
                if (s) begin
                    m_fe = m_busy; m_busy = 1'b1; m_cnt = 1;
                end else if (!m_busy) begin
                    m_fe = 1'b1;
                end else begin
                    m_cnt++;
                    if (m_cnt == W) begin m_busy = 1'b0; m_done = 1'b1; m_cnt = 0; end
                end
                if (diff_q.size() == 0) chk("diff_q_underflow", 1, 0);
                else begin
                    de = diff_q.pop_front();
                    if (de[1]) chk("diff_bit", uo_out[0], de[0]);
                end
            end
            if (m_done) begin
                if (word_q.size() == 0) chk("word_q_underflow", 1, 0);
                else begin
                    we = word_q.pop_front();
                    exp_word = we[7:0];
                    exp_bor  = we[8];
                end
            end
            if (uo_out[2] === 1'b1) n_done_seen++;
            chk("done", uo_out[2], m_done);
            chk("busy", uo_out[3], m_busy);
            chk("frame_err", uo_out[4], m_fe);
            chk("uio_out", uio_out, exp_word);
            chk("borrow", uo_out[1], exp_bor);
            chk("uo_hi", uo_out[7:5], 3'b000);
        end
    end

    task automatic drive(input logic v, input logic s, input logic a, input logic b);
        @(negedge clk);
        ui_in = {4'b0000, s, v, b, a};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Streams nbits of A-B LSB-first; only a full word is expected to complete.
    task automatic send_word(input logic [7:0] a, input logic [7:0] b, input int nbits,
                             input bit gaps);
        logic [7:0] d;
        d = a - b;
        for (int i = 0; i < nbits; i++) begin
            if (gaps && i > 0) idle($urandom_range(1, 5));
            drive(1'b1, i == 0, a[i], b[i]);
            diff_q.push_back({1'b1, d[i]});
        end
        if (nbits == W) begin
            word_q.push_back({a < b, d});
            n_words++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'hFF);
        rst_n = 1'b1;

        send_word(8'h35, 8'h12, W, 1'b0);
        idle(3);

        send_word(8'h12, 8'h35, W, 1'b0);
        send_word(8'h00, 8'h01, W, 1'b0);
        send_word(8'hFF, 8'hFF, W, 1'b0);
        idle(3);

        send_word(8'hA7, 8'h3C, W, 1'b1);
        idle(2);

        send_word(8'h5A, 8'h33, 3, 1'b0);
        send_word(8'h80, 8'h7F, W, 1'b0);
        idle(2);
        chk("fe_after_abort", uo_out[4], 1'b1);
        chk("abort_result", uio_out, 8'h01);

        send_word(8'hC3, 8'h41, W, 1'b0);
        idle(2);
        chk("fe_cleared", uo_out[4], 1'b0);

        drive(1'b1, 1'b0, 1'b1, 1'b0);
        diff_q.push_back(2'b00);
        idle(2);
        chk("idle_bit_fe", uo_out[4], 1'b1);
        chk("idle_bit_busy", uo_out[3], 1'b0);
        chk("idle_bit_word", uio_out, 8'h82);

        send_word(8'h77, 8'h11, 4, 1'b0);
        @(negedge clk);
        ui_in = 8'h00;
        rst_n = 1'b0;
        #1;
        chk("async_rst_uo_out", uo_out, 8'h00);
        chk("async_rst_uio_out", uio_out, 8'h00);
        chk("async_rst_uio_oe", uio_oe, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send_word(8'h10, 8'h01, W, 1'b0);
        idle(3);
        chk("post_rst_word", uio_out, 8'h0F);
        chk("post_rst_borrow", uo_out[1], 1'b0);

        chk("word_q_empty", word_q.size(), 0);
        chk("diff_q_empty", diff_q.size(), 0);
        chk("done_count", n_done_seen, n_words);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
